// File: rtl/pc_pkg.sv
// pc_pkg -- shared definitions for the program-counter generator.
//
// Contents:
//   PRI_*               2-bit redirect priority codes (higher value wins)
//   EXC_VECTOR_DEFAULT  default exception handler address
//   PC_MAX_W            widest PC the helper function handles
//   align_addr()        clears the low log2(instr_bytes) bits of an address
package pc_pkg;

  localparam int unsigned PC_MAX_W = 64;

  localparam logic [1:0] PRI_NONE = 2'd0;
  localparam logic [1:0] PRI_JMP  = 2'd1;
  localparam logic [1:0] PRI_BR   = 2'd2;
  localparam logic [1:0] PRI_EXC  = 2'd3;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0080;

  // instr_bytes must be a power of two; callers zero-extend narrower
  // addresses to PC_MAX_W and take back the low bits they need.
  function automatic logic [PC_MAX_W-1:0] align_addr(
    input logic [PC_MAX_W-1:0] addr,
    input int unsigned         instr_bytes
  );
    logic [PC_MAX_W-1:0] mask;
    mask = ~(PC_MAX_W'(instr_bytes) - PC_MAX_W'(1));
    return addr & mask;
  endfunction

endpackage

// File: rtl/pc_redirect_arb.sv
// pc_redirect_arb -- combinational redirect arbiter.
//
// Picks the highest-priority incoming request (exc > br > jmp), then lets
// a held (pending) redirect win if its priority is greater than or equal
// to the incoming one: on a tie the pending redirect is older and wins.
//
// Ports:
//   exc_valid_i / exc_target_i   exception request and handler address
//   br_valid_i  / br_target_i    MEM-stage taken branch
//   jmp_valid_i / jmp_target_i   ID-stage jump (target already formed)
//   pend_valid_i/_pri_i/_target_i  held redirect slot
//   win_valid_o/_pri_o/_target_o   winning redirect (unaligned target)
module pc_redirect_arb
  import pc_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              exc_valid_i,
  input  logic [ADDR_W-1:0] exc_target_i,
  input  logic              br_valid_i,
  input  logic [ADDR_W-1:0] br_target_i,
  input  logic              jmp_valid_i,
  input  logic [ADDR_W-1:0] jmp_target_i,
  input  logic              pend_valid_i,
  input  logic [1:0]        pend_pri_i,
  input  logic [ADDR_W-1:0] pend_target_i,
  output logic              win_valid_o,
  output logic [1:0]        win_pri_o,
  output logic [ADDR_W-1:0] win_target_o
);

  logic [1:0]        in_pri;
  logic [ADDR_W-1:0] in_target;

  always_comb begin
    in_pri    = PRI_NONE;
    in_target = '0;
    if (exc_valid_i) begin
      in_pri    = PRI_EXC;
      in_target = exc_target_i;
    end else if (br_valid_i) begin
      in_pri    = PRI_BR;
      in_target = br_target_i;
    end else if (jmp_valid_i) begin
      in_pri    = PRI_JMP;
      in_target = jmp_target_i;
    end
  end

  always_comb begin
    win_valid_o  = pend_valid_i || (in_pri != PRI_NONE);
    win_pri_o    = in_pri;
    win_target_o = in_target;
    if (pend_valid_i && (pend_pri_i >= in_pri)) begin
      win_pri_o    = pend_pri_i;
      win_target_o = pend_target_i;
    end
  end

endmodule

// File: rtl/pc_gen_unit.sv
// pc_gen_unit -- fetch program-counter generator.
//
// Holds the fetch PC, arbitrates redirects (exception > MEM branch >
// ID jump > sequential), merges NUM_WE stall sources and keeps a redirect
// that arrives during a stall until the PC is allowed to move again.
//
// Fetch handshake: fetch_valid says curr_pc is a live request; the request
// is consumed on a rising edge where fetch_valid && fetch_ready, and only
// then (absent a redirect, with all write enables high) does the PC step
// to pc_plus. A redirect replaces curr_pc without waiting for fetch_ready,
// since the outstanding fetch is squashed by flush.
//
// Ports:
//   Clk, Reset_n         clock (rising edge), async active-low reset
//   pc_we[NUM_WE]        write enables; PC changes only when all are 1
//   fetch_ready          instruction memory accepts curr_pc
//   exc_valid            exception redirect to EXC_VECTOR
//   br_valid, br_target  MEM-stage taken branch
//   jmp_valid, jmp_abs, jmp_index, jmp_reg   ID-stage jump (j/jal or jr)
//   curr_pc, pc_plus, next_pc   current, incremented and next PC
//   fetch_valid          curr_pc is a valid fetch request
//   flush                redirect applied this cycle (IF/ID flush)
//   pend_valid           a stalled redirect is being held
//   misalign             one-cycle pulse after applying a misaligned target
//
// ADDR_W may be at most pc_pkg::PC_MAX_W.
module pc_gen_unit
  import pc_pkg::*;
#(
  parameter int unsigned       ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter logic [31:0]       EXC_VECTOR   = EXC_VECTOR_DEFAULT,
  parameter int unsigned       NUM_WE       = 2,
  parameter int unsigned       INSTR_BYTES  = 4
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [NUM_WE-1:0] pc_we,
  input  logic              fetch_ready,
  input  logic              exc_valid,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              jmp_valid,
  input  logic              jmp_abs,
  input  logic [ADDR_W-7:0] jmp_index,
  input  logic [ADDR_W-1:0] jmp_reg,
  output logic [ADDR_W-1:0] curr_pc,
  output logic [ADDR_W-1:0] pc_plus,
  output logic [ADDR_W-1:0] next_pc,
  output logic              fetch_valid,
  output logic              flush,
  output logic              pend_valid,
  output logic              misalign
);

  logic [ADDR_W-1:0] curr_pc_q,     curr_pc_d;
  logic              pend_valid_q,  pend_valid_d;
  logic [1:0]        pend_pri_q,    pend_pri_d;
  logic [ADDR_W-1:0] pend_target_q, pend_target_d;
  logic              fetch_valid_q;
  logic              misalign_q,    misalign_d;

  logic              we_all;
  logic [ADDR_W-1:0] exc_target;
  logic [ADDR_W-1:0] jmp_target;
  logic              win_valid;
  logic [1:0]        win_pri;
  logic [ADDR_W-1:0] win_target;
  logic [PC_MAX_W-1:0] win_full;
  logic [PC_MAX_W-1:0] win_aligned_full;
  logic [ADDR_W-1:0] win_aligned;
  logic              win_misalign;

  assign we_all     = &pc_we;
  assign pc_plus    = curr_pc_q + ADDR_W'(INSTR_BYTES);
  assign exc_target = ADDR_W'(EXC_VECTOR);

  // Region jumps keep the top nibble of the sequential PC.
  assign jmp_target = jmp_abs ? {pc_plus[ADDR_W-1 -: 4], jmp_index, 2'b00}
                              : jmp_reg;

  pc_redirect_arb #(
    .ADDR_W (ADDR_W)
  ) u_arb (
    .exc_valid_i   (exc_valid),
    .exc_target_i  (exc_target),
    .br_valid_i    (br_valid),
    .br_target_i   (br_target),
    .jmp_valid_i   (jmp_valid),
    .jmp_target_i  (jmp_target),
    .pend_valid_i  (pend_valid_q),
    .pend_pri_i    (pend_pri_q),
    .pend_target_i (pend_target_q),
    .win_valid_o   (win_valid),
    .win_pri_o     (win_pri),
    .win_target_o  (win_target)
  );

  // The pending slot stores the raw target; alignment and the misalign
  // flag are produced only when the redirect is actually applied.
  assign win_full         = PC_MAX_W'(win_target);
  assign win_aligned_full = align_addr(win_full, INSTR_BYTES);
  assign win_aligned      = win_aligned_full[ADDR_W-1:0];
  assign win_misalign     = (win_aligned_full != win_full);

  always_comb begin
    if (win_valid) begin
      next_pc = win_aligned;
    end else if (fetch_ready && fetch_valid_q) begin
      next_pc = pc_plus;
    end else begin
      next_pc = curr_pc_q;
    end
  end

  assign flush = we_all && win_valid;

  always_comb begin
    curr_pc_d     = curr_pc_q;
    pend_valid_d  = pend_valid_q;
    pend_pri_d    = pend_pri_q;
    pend_target_d = pend_target_q;
    misalign_d    = 1'b0;
    if (we_all) begin
      curr_pc_d = next_pc;
      if (win_valid) begin
        pend_valid_d = 1'b0;
        pend_pri_d   = PRI_NONE;
        misalign_d   = win_misalign;
      end
    end else if (win_valid) begin
      // Winner already accounts for the held slot, so a weaker or equal
      // incoming request leaves the pending redirect unchanged.
      pend_valid_d  = 1'b1;
      pend_pri_d    = win_pri;
      pend_target_d = win_target;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      curr_pc_q     <= RESET_VECTOR;
      pend_valid_q  <= 1'b0;
      pend_pri_q    <= PRI_NONE;
      pend_target_q <= '0;
      fetch_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      curr_pc_q     <= curr_pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_pri_q    <= pend_pri_d;
      pend_target_q <= pend_target_d;
      fetch_valid_q <= 1'b1;
      misalign_q    <= misalign_d;
    end
  end

  assign curr_pc     = curr_pc_q;
  assign fetch_valid = fetch_valid_q;
  assign pend_valid  = pend_valid_q;
  assign misalign    = misalign_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
// tb_pc_gen_unit -- directed bench for pc_gen_unit with default parameters
// (32-bit PC, reset vector 0, exception vector 0x80, two write enables,
// 4-byte instructions). A reference model checks every output each cycle
// on the falling edge; directed literal checks pin the model.
module tb_pc_gen_unit;

  // ---------------- clock / reset ----------------
  logic        Clk;
  logic        Reset_n;
  logic [1:0]  pc_we;
  logic        fetch_ready;
  logic        exc_valid;
  logic        br_valid;
  logic [31:0] br_target;
  logic        jmp_valid;
  logic        jmp_abs;
  logic [25:0] jmp_index;
  logic [31:0] jmp_reg;
  logic [31:0] curr_pc;
  logic [31:0] pc_plus;
  logic [31:0] next_pc;
  logic        fetch_valid;
  logic        flush;
  logic        pend_valid;
  logic        misalign;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  pc_gen_unit dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .pc_we       (pc_we),
    .fetch_ready (fetch_ready),
    .exc_valid   (exc_valid),
    .br_valid    (br_valid),
    .br_target   (br_target),
    .jmp_valid   (jmp_valid),
    .jmp_abs     (jmp_abs),
    .jmp_index   (jmp_index),
    .jmp_reg     (jmp_reg),
    .curr_pc     (curr_pc),
    .pc_plus     (pc_plus),
    .next_pc     (next_pc),
    .fetch_valid (fetch_valid),
    .flush       (flush),
    .pend_valid  (pend_valid),
    .misalign    (misalign)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_* holds the architectural state visible between rising edges.
  logic [31:0] m_pc, m_pt;
  logic [1:0]  m_pp;
  logic        m_fv, m_pv, m_mis;

  always @(negedge Clk) begin : model_cmp
    logic [31:0] pcp, in_t, eff_t, exp_next;
    logic [1:0]  in_p, eff_p;
    logic        eff_v, we;
    if (!Reset_n) begin
      m_pc = 32'h0; m_pt = 32'h0; m_pp = 2'd0;
      m_fv = 1'b0;  m_pv = 1'b0;  m_mis = 1'b0;
    end
    pcp  = m_pc + 32'd4;
    in_p = 2'd0;
    in_t = 32'h0;
    if (exc_valid) begin
      in_p = 2'd3; in_t = 32'h80;
    end else if (br_valid) begin
      in_p = 2'd2; in_t = br_target;
    end else if (jmp_valid) begin
      in_p = 2'd1;
      in_t = jmp_abs ? {pcp[31:28], jmp_index, 2'b00} : jmp_reg;
    end
    if (m_pv && (m_pp >= in_p)) begin
      eff_v = 1'b1; eff_p = m_pp; eff_t = m_pt;
    end else begin
      eff_v = (in_p != 2'd0); eff_p = in_p; eff_t = in_t;
    end
    we       = pc_we[0] && pc_we[1];
    exp_next = eff_v ? (eff_t & 32'hFFFF_FFFC)
             : ((fetch_ready && m_fv) ? pcp : m_pc);

    check("m_curr_pc",     curr_pc,            m_pc);
    check("m_pc_plus",     pc_plus,            pcp);
    check("m_next_pc",     next_pc,            exp_next);
    check("m_fetch_valid", 32'(fetch_valid),   32'(m_fv));
    check("m_flush",       32'(flush),         32'(we && eff_v));
    check("m_pend_valid",  32'(pend_valid),    32'(m_pv));
    check("m_misalign",    32'(misalign),      32'(m_mis));

    if (Reset_n) begin
      m_mis = we && eff_v && (eff_t[1:0] != 2'b00);
      if (we) begin
        m_pc = exp_next;
        if (eff_v) m_pv = 1'b0;
      end else if (eff_v) begin
        m_pv = 1'b1; m_pp = eff_p; m_pt = eff_t;
      end
      m_fv = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    exc_valid = 1'b0;
    br_valid  = 1'b0;
    jmp_valid = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    Reset_n     = 1'b0;
    pc_we       = 2'b11;
    fetch_ready = 1'b1;
    br_target   = 32'h0;
    jmp_abs     = 1'b0;
    jmp_index   = 26'h0;
    jmp_reg     = 32'h0;
    idle();
    repeat (3) tick();
    check("reset_pc",    curr_pc,           32'h0);
    check("reset_fv",    32'(fetch_valid),  32'h0);
    check("reset_pend",  32'(pend_valid),   32'h0);
    check("reset_mis",   32'(misalign),     32'h0);

    // sequential fetch: 0, 0, 4, 8, 12, 16
    Reset_n = 1'b1;
    exp_q.push_back(32'h0);
    for (int k = 0; k < 5; k++) exp_q.push_back(32'(k * 4));
    check("fv_before_edge", 32'(fetch_valid), 32'h0);
    check("seq_pc", curr_pc, exp_q.pop_front());
    for (int i = 0; i < 5; i++) begin
      tick();
      check("seq_pc", curr_pc, exp_q.pop_front());
      if (i == 0) check("fv_after_edge", 32'(fetch_valid), 32'h1);
    end

    // backpressure at 0x10
    fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold", curr_pc, 32'h10);
      check("bp_flush", 32'(flush), 32'h0);
    end
    fetch_ready = 1'b1;
    tick();
    check("bp_resume", curr_pc, 32'h14);
    repeat (3) tick();
    check("at_0x20", curr_pc, 32'h20);

    // all three requests at once: exception wins
    exc_valid = 1'b1; br_valid = 1'b1; br_target = 32'h100;
    jmp_valid = 1'b1; jmp_abs = 1'b1; jmp_index = 26'h40;
    #1;
    check("prio_flush", 32'(flush), 32'h1);
    check("prio_next",  next_pc,    32'h80);
    tick();
    idle();
    #1;
    check("prio_pc",     curr_pc,    32'h80);
    check("prio_flush0", 32'(flush), 32'h0);

    // branch during stall is kept
    pc_we = 2'b01; br_valid = 1'b1; br_target = 32'h200;
    #1;
    check("stall_flush", 32'(flush), 32'h0);
    tick();
    br_valid = 1'b0;
    #1;
    check("stall_pend", 32'(pend_valid), 32'h1);
    check("stall_hold", curr_pc,         32'h80);
    repeat (2) tick();
    pc_we = 2'b11;
    #1;
    check("release_flush", 32'(flush), 32'h1);
    check("release_next",  next_pc,    32'h200);
    tick();
    check("release_pc",   curr_pc,         32'h200);
    check("release_pend", 32'(pend_valid), 32'h0);

    // pending jr 0x300 overridden by exception
    pc_we = 2'b01; jmp_valid = 1'b1; jmp_abs = 1'b0; jmp_reg = 32'h300;
    tick();
    jmp_valid = 1'b0; exc_valid = 1'b1;
    tick();
    exc_valid = 1'b0; pc_we = 2'b11;
    #1;
    check("ovr_exc_next", next_pc, 32'h80);
    tick();
    check("ovr_exc_pc", curr_pc, 32'h80);

    // pending branch beats incoming jump
    pc_we = 2'b01; br_valid = 1'b1; br_target = 32'h200;
    tick();
    br_valid = 1'b0; jmp_valid = 1'b1; jmp_abs = 1'b0; jmp_reg = 32'h300;
    pc_we = 2'b11;
    #1;
    check("pend_br_next", next_pc, 32'h200);
    tick();
    idle();
    #1;
    check("pend_br_pc", curr_pc, 32'h200);

    // equal priority: older pending branch wins
    pc_we = 2'b01; br_valid = 1'b1; br_target = 32'h240;
    tick();
    br_target = 32'h300; pc_we = 2'b11;
    #1;
    check("tie_next", next_pc, 32'h240);
    tick();
    idle();
    #1;
    check("tie_pc", curr_pc, 32'h240);

    // misaligned register jump
    jmp_valid = 1'b1; jmp_abs = 1'b0; jmp_reg = 32'h1003;
    #1;
    check("mis_next", next_pc, 32'h1000);
    tick();
    idle();
    #1;
    check("mis_pc",    curr_pc,       32'h1000);
    check("mis_pulse", 32'(misalign), 32'h1);
    tick();
    check("mis_clear", 32'(misalign), 32'h0);
    check("mis_seq",   curr_pc,       32'h1004);

    // region jump keeps the top nibble of pc_plus
    jmp_valid = 1'b1; jmp_abs = 1'b0; jmp_reg = 32'h3000_0000;
    tick();
    jmp_abs = 1'b1; jmp_index = 26'h40;
    #1;
    check("abs_next", next_pc, 32'h3000_0100);
    tick();
    idle();
    #1;
    check("abs_pc", curr_pc, 32'h3000_0100);

    // pc_plus wraps to 0
    jmp_valid = 1'b1; jmp_abs = 1'b0; jmp_reg = 32'hFFFF_FFFC;
    tick();
    idle();
    #1;
    check("wrap_top",  curr_pc, 32'hFFFF_FFFC);
    check("wrap_plus", pc_plus, 32'h0);
    tick();
    check("wrap_pc", curr_pc, 32'h0);

    // async reset mid-stall discards the pending redirect
    tick();
    check("pre_rst_pc", curr_pc, 32'h4);
    pc_we = 2'b01; br_valid = 1'b1; br_target = 32'h500;
    tick();
    br_valid = 1'b0;
    #1;
    check("pre_rst_pend", 32'(pend_valid), 32'h1);
    #1;
    Reset_n = 1'b0;
    #1;
    check("async_rst_pend", 32'(pend_valid),  32'h0);
    check("async_rst_pc",   curr_pc,          32'h0);
    check("async_rst_fv",   32'(fetch_valid), 32'h0);
    tick();
    Reset_n = 1'b1; pc_we = 2'b11;
    tick();
    tick();
    check("post_rst_pc",   curr_pc,         32'h4);
    check("post_rst_pend", 32'(pend_valid), 32'h0);

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_gen_unit.md
Name: pc_gen_unit

Overview:
- Parametrised successor to the single-issue program counter.
- Generates the fetch PC for the IF stage and arbitrates redirect sources by priority: exception, then MEM branch, then ID jump, then sequential.
- Combines N write-enable (stall) sources.
- Remembers a redirect that arrives while the PC is stalled, so no branch or jump is lost.
- Drives a valid/ready fetch handshake toward instruction memory.

Parameters:
- ADDR_W, 32, PC and target width.
- RESET_VECTOR, 0, PC value at reset.
- EXC_VECTOR, 32'h0000_0080, exception handler address (truncated to ADDR_W).
- NUM_WE, 2, number of PC write-enable sources (e.g. control unit, load-use unit).
- INSTR_BYTES, 4, sequential increment; power of two.

Ports:
- Clk  in  1  clock, rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- pc_we  in  NUM_WE  per-source write enables; the PC may change only when all bits are 1.
- fetch_ready  in  1  instruction memory accepts curr_pc this cycle.
- exc_valid  in  1  exception redirect request.
- br_valid  in  1  MEM-stage taken branch.
- br_target  in  ADDR_W  branch target.
- jmp_valid  in  1  ID-stage jump.
- jmp_abs  in  1  1 = region jump (j/jal), 0 = register jump (jr).
- jmp_index  in  ADDR_W-6  26-bit instruction index when ADDR_W=32.
- jmp_reg  in  ADDR_W  rs value for register jumps.
- curr_pc  out  ADDR_W  current fetch address.
- pc_plus  out  ADDR_W  curr_pc+INSTR_BYTES, combinational.
- next_pc  out  ADDR_W  value loaded at the next update, combinational.
- fetch_valid  out  1  curr_pc is a valid fetch request.
- flush  out  1  a redirect is applied this cycle (combinational); IF/ID flush.
- pend_valid  out  1  a stalled redirect is held.
- misalign  out  1  registered one-cycle pulse when an applied target had nonzero low bits.

Behaviour:
- Reset (Reset_n=0, asynchronous):
  - curr_pc=RESET_VECTOR, fetch_valid=0, pend_valid=0, misalign=0.
  - Pending target and priority registers cleared.
  - A reset asserted mid-stall discards the pending redirect.
- fetch_valid goes to 1 on the first rising edge after Reset_n rises and stays 1.
- we_all = AND of all pc_we bits.
- Jump target:
  - jmp_abs=1: {pc_plus[ADDR_W-1:ADDR_W-4], jmp_index, 2'b00}.
  - jmp_abs=0: jmp_reg.
- Incoming request priority: exc(3) > br(2) > jmp(1) > none(0). The highest-priority asserted request wins.
- Effective redirect:
  - The pending redirect is used if pend_valid=1 and its priority ≥ the incoming priority.
  - Otherwise the incoming request is used.
  - Equal priority: the pending redirect wins, because it is older.
- Update at the rising edge when we_all=1:
  - If an effective redirect exists: curr_pc ← target with the low log2(INSTR_BYTES) bits forced to 0. Then flush=1, pend_valid ← 0, and misalign ← 1 if any forced bit was 1.
  - Else if fetch_ready=1 and fetch_valid=1: curr_pc ← pc_plus.
  - Else: curr_pc holds.
- Redirect while we_all=0:
  - curr_pc holds and flush=0.
  - The effective redirect is captured into the pending registers (target, priority), with pend_valid ← 1.
  - A later incoming request of higher priority replaces the pending one; lower or equal priority is dropped.
- A redirect is applied regardless of fetch_ready, because the outstanding fetch is squashed.
- next_pc is the value curr_pc would take if we_all=1, including the pending redirect.
- Arithmetic is modulo 2^ADDR_W: pc_plus wraps from the all-ones region to 0 without a flag.
- Latency: a redirect presented in cycle t is visible on curr_pc in cycle t+1 when unstalled, or in the cycle after the first we_all=1 edge otherwise.
- misalign is 0 in every cycle except the one following an applied misaligned redirect.

Decomposition:
- Shared package pc_pkg holds:
  - localparam priority codes PRI_NONE/JMP/BR/EXC (2-bit).
  - Default EXC_VECTOR.
  - A function align_addr(addr, INSTR_BYTES).
- One sub-module is natural: pc_redirect_arb. It is combinational: it takes the three requests plus the pending slot and produces the winning target, priority and valid.
- The top level holds curr_pc, the pending registers, fetch_valid and misalign.

Test Plan:
- Reset and sequential fetch: Reset_n low then high, pc_we=2'b11, fetch_ready=1 → curr_pc 0, 0, 4, 8, 12; fetch_valid goes 1 after the first edge.
- Backpressure: fetch_ready=0 for 3 cycles at curr_pc=0x10 → holds 0x10; resumes 0x14 after ready returns; flush=0 throughout.
- Priority: curr_pc=0x20, exc_valid, br_valid(0x100) and jmp_valid(abs, index=0x40) all asserted → next curr_pc=0x80, flush=1 for one cycle.
- Stalled branch kept: pc_we=2'b01, br_valid with br_target=0x200 for one cycle → pend_valid=1, curr_pc unchanged; pc_we=2'b11 two cycles later → curr_pc=0x200, pend_valid=0.
- Pending override: pending jmp_reg=0x300, then exc while still stalled → on release curr_pc=0x80. Pending br 0x200 plus incoming jmp on release → curr_pc=0x200.
- Misaligned register jump and async reset: jmp_abs=0, jmp_reg=0x1003 → curr_pc=0x1000, misalign pulses one cycle. Reset_n low mid-stall with pending → pend_valid=0 and curr_pc=RESET_VECTOR immediately, without waiting for a clock edge.
